// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequenced signed multiply/divide unit owning the Hi/Lo registers.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset, clears all state
//   start    - request, sampled only in IDLE
//   op       - 0 = MULT (signed), 1 = DIV (signed), sampled with start
//   a, b     - multiplicand/dividend and multiplier/divisor, sampled with start
//   busy     - high whenever the FSM is not IDLE
//   done     - one-cycle pulse; hi/lo hold the new result in this cycle
//   div_zero - one-cycle pulse together with done for DIV with b == 0
//   hi, lo   - Hi and Lo registers
//
// Handshake: start is a request accepted on the first rising edge that finds
// the FSM in IDLE; it is ignored at every other time and is not queued. The
// result is signalled by done, a single-cycle pulse that needs no acknowledge.
//
// Both operations run on magnitudes through one shared 2*WIDTH accumulator:
//   MULT: acc = {partial product, remaining multiplier bits}, shift-add right.
//   DIV : acc = {partial remainder, dividend/quotient bits}, restoring shift
//         left, one quotient bit entering at the bottom per iteration.
// Signs are applied in a single FIX cycle afterwards.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic               qneg_q, qneg_d;     // result/quotient is negative
  logic               rneg_q, rneg_d;     // remainder takes dividend sign
  logic               dz_q, dz_d;         // accepted request was DIV by zero
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes; -MIN wraps to 2^(WIDTH-1), which is correct unsigned.
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial_sub;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    mag_a     = a[WIDTH-1] ? -a : a;
    mag_b     = b[WIDTH-1] ? -b : b;
    // Multiply step: add multiplicand to the upper half, keep the carry.
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    // Divide step: remainder shifted left with the next dividend bit.
    trial     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial_ge  = (trial >= {1'b0, mag_q});
    // Only used when trial >= divisor, so the difference fits in WIDTH bits.
    trial_sub = trial[WIDTH-1:0] - mag_q;
    prod_neg  = -acc_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          cnt_d  = CW'(WIDTH - 1);
          dz_d   = op && (b == '0);
          if (op) begin
            mag_d = mag_b;
            acc_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            mag_d = mag_a;
            acc_d = {{WIDTH{1'b0}}, mag_b};
          end
          // Divide by zero skips the datapath and leaves Hi/Lo untouched.
          state_d = (op && (b == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (op_q) begin
          acc_d = {(trial_ge ? trial_sub : trial[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], trial_ge};
        end else if (acc_q[0]) begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q) begin
          lo_d = qneg_q ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = qneg_q ? prod_neg : acc_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Moore outputs: decoded from state or taken straight from registers.
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
